ldpc_layer_sched: RTL and testbench

Layer/iteration scheduler for the layered min-sum QC-LDPC decoder row datapath (VNAP bank + CNU). Per layer, it drives the datapath `sel` phase, memory read/write strobes and the layer address, and waits out the CNU latency. After each full pass over all layers it checks the external syndrome result. It stops on syndrome pass, on iteration limit, or on abort.

---
 rtl/ldpc_pkg.sv | 18 +
 rtl/ldpc_wrap_cnt.sv | 26 ++
 rtl/ldpc_layer_sched.sv | 170 +++++++++++++++++
 tb/tb_ldpc_layer_sched.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_pkg.sv
// Shared types and default sizing for the layered LDPC decoder control path.
package ldpc_pkg;

    localparam int unsigned NLAYERS   = 12;
    localparam int unsigned MAX_ITER  = 10;
    localparam int unsigned CNU_LAT   = 2;
    localparam int unsigned WAIT_BITS = 3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PH_A  = 3'd1,
        S_WAIT  = 3'd2,
        S_PH_B  = 3'd3,
        S_CHECK = 3'd4,
        S_FIN   = 3'd5
    } sched_state_t;

endpackage

// File: rtl/ldpc_wrap_cnt.sv
// Modulo-N counter with synchronous clear, increment enable and terminal-count flag.
module ldpc_wrap_cnt #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         last
);

    assign last = (count == W'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= last ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/ldpc_layer_sched.sv
// Layer/iteration scheduler: sequences read, CNU wait and write per layer, then a
// syndrome check per iteration, until syndrome pass, iteration limit or abort.
module ldpc_layer_sched #(
    parameter int unsigned NLAYERS  = ldpc_pkg::NLAYERS,
    parameter int unsigned MAX_ITER = ldpc_pkg::MAX_ITER,
    parameter int unsigned CNU_LAT  = ldpc_pkg::CNU_LAT,
    parameter int unsigned LBITS    = $clog2(NLAYERS),
    parameter int unsigned IBITS    = $clog2(MAX_ITER + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             syn_ok,
    output logic             busy,
    output logic             sel,
    output logic             rd_en,
    output logic             wr_en,
    output logic [LBITS-1:0] layer,
    output logic [IBITS-1:0] iter,
    output logic             syn_clr,
    output logic             done,
    output logic             success,
    output logic [IBITS-1:0] iters_used
);

    import ldpc_pkg::*;

    sched_state_t         state, state_nx;
    logic [WAIT_BITS-1:0] wait_cnt;
    logic                 layer_clr, layer_inc, layer_last;
    logic                 iter_clr, iter_inc, iter_last;
    logic                 wait_load, wait_clr;
    logic                 res_latch, res_ok, clr_pulse;

    ldpc_wrap_cnt #(.N(NLAYERS), .W(LBITS)) u_layer_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (layer_clr),
        .inc   (layer_inc),
        .count (layer),
        .last  (layer_last)
    );

    ldpc_wrap_cnt #(.N(MAX_ITER), .W(IBITS)) u_iter_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (iter_clr),
        .inc   (iter_inc),
        .count (iter),
        .last  (iter_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        layer_clr = 1'b0;
        layer_inc = 1'b0;
        iter_clr  = 1'b0;
        iter_inc  = 1'b0;
        wait_load = 1'b0;
        wait_clr  = 1'b0;
        res_latch = 1'b0;
        res_ok    = 1'b0;
        clr_pulse = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx  = S_PH_A;
                    layer_clr = 1'b1;
                    iter_clr  = 1'b1;
                    clr_pulse = 1'b1;
                end
            end
            S_PH_A: begin
                state_nx  = S_WAIT;
                wait_load = 1'b1;
            end
            S_WAIT: begin
                if (wait_cnt == '0) begin
                    state_nx = S_PH_B;
                end
            end
            S_PH_B: begin
                layer_inc = 1'b1;
                state_nx  = layer_last ? S_CHECK : S_PH_A;
            end
            S_CHECK: begin
                if (syn_ok) begin
                    state_nx  = S_FIN;
                    res_latch = 1'b1;
                    res_ok    = 1'b1;
                end else if (iter_last) begin
                    state_nx  = S_FIN;
                    res_latch = 1'b1;
                end else begin
                    state_nx  = S_PH_A;
                    iter_inc  = 1'b1;
                    clr_pulse = 1'b1;
                end
            end
            S_FIN: begin
                state_nx  = S_IDLE;
                layer_clr = 1'b1;
                iter_clr  = 1'b1;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
        // Abort wins over any decision taken above, including the CHECK verdict.
        if (abort && (state inside {S_PH_A, S_WAIT, S_PH_B, S_CHECK})) begin
            state_nx  = S_IDLE;
            layer_clr = 1'b1;
            iter_clr  = 1'b1;
            layer_inc = 1'b0;
            iter_inc  = 1'b0;
            wait_load = 1'b0;
            wait_clr  = 1'b1;
            res_latch = 1'b0;
            clr_pulse = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (wait_clr) begin
            wait_cnt <= '0;
        end else if (wait_load) begin
            wait_cnt <= WAIT_BITS'(CNU_LAT - 1);
        end else if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WAIT_BITS'(1);
        end
    end

    // Strobes are flopped from the next-state decode so they line up with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= 1'b0;
            sel        <= 1'b0;
            rd_en      <= 1'b0;
            wr_en      <= 1'b0;
            done       <= 1'b0;
            success    <= 1'b0;
            iters_used <= '0;
        end else begin
            busy  <= (state_nx != S_IDLE);
            sel   <= (state_nx == S_PH_B);
            rd_en <= (state_nx == S_PH_A);
            wr_en <= (state_nx == S_PH_B);
            done  <= (state_nx == S_FIN);
            if (res_latch) begin
                success    <= res_ok;
                iters_used <= iter + IBITS'(1);
            end
        end
    end

    // The syndrome accumulator clears on the very edge that starts an iteration.
    assign syn_clr = clr_pulse & ~rst;

endmodule

// File: tb/tb_ldpc_layer_sched.sv
// Directed bench for ldpc_layer_sched with a cycle-schedule reference model.
module tb_ldpc_layer_sched;

    localparam int NL  = 4;
    localparam int MI  = 3;
    localparam int LAT = 2;
    localparam int L   = LAT + 2;
    localparam int T   = NL * L + 1;

    logic       clk = 1'b0;
    logic       rst, start, abort, syn_ok, start2;
    logic       busy, sel, rd_en, wr_en, syn_clr, done, success;
    logic [1:0] layer, iter, iters_used;
    logic       busy2, sel2, rd2, wr2, clr2, done2, succ2;
    logic [1:0] layer2, iter2, used2;
    logic       zero = 1'b0;

    ldpc_layer_sched #(.NLAYERS(NL), .MAX_ITER(MI), .CNU_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .syn_ok(syn_ok),
        .busy(busy), .sel(sel), .rd_en(rd_en), .wr_en(wr_en), .layer(layer),
        .iter(iter), .syn_clr(syn_clr), .done(done), .success(success),
        .iters_used(iters_used)
    );

    ldpc_layer_sched #(.NLAYERS(NL), .MAX_ITER(MI), .CNU_LAT(1)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(zero), .syn_ok(zero),
        .busy(busy2), .sel(sel2), .rd_en(rd2), .wr_en(wr2), .layer(layer2),
        .iter(iter2), .syn_clr(clr2), .done(done2), .success(succ2),
        .iters_used(used2)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: where the decode is, purely in terms of cycles since start.
    bit m_busy = 0, m_fin = 0, m_succ = 0;
    int m_s = 0, m_used = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always begin : model
        int t, r;
        @(posedge clk or posedge rst);
        if (rst) begin
            m_busy = 0; m_fin = 0; m_succ = 0; m_used = 0;
        end else if (!m_busy) begin
            if (start) begin m_busy = 1; m_fin = 0; m_s = cyc; end
        end else if (m_fin) begin
            m_busy = 0; m_fin = 0;
        end else if (abort) begin
            m_busy = 0;
        end else begin
            t = cyc - m_s - 1;
            r = t % T;
            if (r == NL * L) begin
                if (syn_ok) begin m_fin = 1; m_succ = 1; m_used = t / T + 1; end
                else if (t / T == MI - 1) begin m_fin = 1; m_succ = 0; m_used = MI; end
            end
        end
    end

    // Observations for the literal end-of-test checks.
    int obs_rd, obs_wr, obs_done_cnt, obs_done_cyc, obs_last_busy, obs_done2_cyc, obs_rd2;
    int obs_clr[$];
    int rdq_c[$], rdq_l[$], rd2q_c[$], rd2q_l[$];

    task automatic clear_obs();
        obs_rd = 0; obs_wr = 0; obs_done_cnt = 0; obs_done_cyc = -1;
        obs_last_busy = -1; obs_done2_cyc = -1; obs_rd2 = 0;
        obs_clr.delete(); rdq_c.delete(); rdq_l.delete(); rd2q_c.delete(); rd2q_l.delete();
    endtask

    always @(negedge clk) begin : cmp
        int t, i, r, ph, e_layer, e_iter, pc, pl;
        bit run, is_chk, e_busy, e_sel, e_rd, e_wr, e_done, e_clr, e_succ;
        int e_used;
        t = 0; i = 0; r = 0; ph = 0; e_layer = 0; e_iter = 0;
        run = 0; is_chk = 0; e_busy = 0; e_sel = 0; e_rd = 0; e_wr = 0;
        e_done = 0; e_clr = 0; e_succ = 0; e_used = 0;
        if (!rst) begin
            run    = m_busy && !m_fin;
            e_busy = m_busy;
            e_done = m_busy && m_fin;
            e_succ = m_succ;
            e_used = m_used;
            if (run) begin
                t = cyc - m_s - 1; i = t / T; r = t % T;
                is_chk = (r == NL * L);
                e_iter = i;
                if (!is_chk) begin
                    e_layer = r / L; ph = r % L;
                    e_rd = (ph == 0); e_wr = (ph == L - 1); e_sel = e_wr;
                end
            end
            e_clr = (!m_busy && start) || (run && is_chk && !syn_ok && !abort && i < MI - 1);
        end
        chk("busy", int'(busy), int'(e_busy));
        chk("sel", int'(sel), int'(e_sel));
        chk("rd_en", int'(rd_en), int'(e_rd));
        chk("wr_en", int'(wr_en), int'(e_wr));
        chk("done", int'(done), int'(e_done));
        chk("syn_clr", int'(syn_clr), int'(e_clr));
        chk("success", int'(success), int'(e_succ));
        chk("iters_used", int'(iters_used), e_used);
        if (run || rst) begin
            chk("layer", int'(layer), e_layer);
            chk("iter", int'(iter), e_iter);
        end
        if (rst) begin
            rdq_c.delete(); rdq_l.delete(); rd2q_c.delete(); rd2q_l.delete();
        end else begin
            if (busy) obs_last_busy = cyc;
            if (syn_clr) obs_clr.push_back(cyc);
            if (done) begin obs_done_cnt++; obs_done_cyc = cyc; end
            if (done2) obs_done2_cyc = cyc;
            if (rd_en) begin obs_rd++; rdq_c.push_back(cyc); rdq_l.push_back(int'(layer)); end
            if (wr_en) begin
                obs_wr++;
                chk("wr_has_rd", rdq_c.size(), 1);
                if (rdq_c.size() > 0) begin
                    pc = rdq_c.pop_front(); pl = rdq_l.pop_front();
                    chk("rd_wr_gap", cyc - pc, 3);
                    chk("wr_layer", int'(layer), pl);
                end
            end
            if (rd2) begin obs_rd2++; rd2q_c.push_back(cyc); rd2q_l.push_back(int'(layer2)); end
            if (wr2) begin
                chk("wr2_has_rd", rd2q_c.size(), 1);
                if (rd2q_c.size() > 0) begin
                    pc = rd2q_c.pop_front(); pl = rd2q_l.pop_front();
                    chk("rd_wr_gap_lat1", cyc - pc, 2);
                    chk("wr2_layer", int'(layer2), pl);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int base, input int budget, input string name);
        int b;
        b = 0;
        while (obs_done_cnt == base && b < budget) begin
            step(1);
            b++;
        end
        chk(name, obs_done_cnt - base, 1);
    endtask

    int k, first_done;
    int exp_clr[3] = '{0, 17, 34};

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; syn_ok = 1'b0; start2 = 1'b0;
        clear_obs();
        step(3);
        chk("reset_busy", int'(busy), 0);
        chk("reset_iters_used", int'(iters_used), 0);
        rst = 1'b0;
        step(2);

        // Full-length fail, plus the CNU_LAT=1 instance in parallel.
        k = cyc; clear_obs(); start = 1'b1; start2 = 1'b1;
        step(1); start = 1'b0; start2 = 1'b0;
        wait_done(0, 80, "full_done_seen");
        chk("full_done_cycle", obs_done_cyc - k, 52);
        chk("full_success", int'(success), 0);
        chk("full_iters_used", int'(iters_used), 3);
        chk("full_rd_count", obs_rd, 12);
        chk("full_wr_count", obs_wr, 12);
        chk("full_clr_count", obs_clr.size(), 3);
        for (int j = 0; j < 3; j++)
            chk("full_clr_cycle", (j < obs_clr.size()) ? obs_clr[j] - k : -1, exp_clr[j]);
        chk("lat1_done_cycle", obs_done2_cyc - k, 40);
        chk("lat1_rd_count", obs_rd2, 12);

        // Early termination; start pulsed during FIN must be ignored.
        step(2);
        k = cyc; clear_obs(); start = 1'b1;
        step(1); start = 1'b0;
        step(16); syn_ok = 1'b1;
        step(1); syn_ok = 1'b0; start = 1'b1;
        step(1); start = 1'b0;
        step(12);
        chk("early_done_count", obs_done_cnt, 1);
        chk("early_done_cycle", obs_done_cyc - k, 18);
        chk("early_success", int'(success), 1);
        chk("early_iters_used", int'(iters_used), 1);
        chk("early_rd_count", obs_rd, 4);
        chk("fin_start_ignored_busy", int'(busy), 0);

        // Abort in the first WAIT cycle of iteration 1, layer 2.
        k = cyc; clear_obs(); start = 1'b1;
        step(1); start = 1'b0;
        step(26); abort = 1'b1;
        step(1); abort = 1'b0;
        step(5);
        chk("abort_last_busy", obs_last_busy - k, 27);
        chk("abort_no_done", obs_done_cnt, 0);
        chk("abort_success_held", int'(success), 1);
        chk("abort_used_held", int'(iters_used), 1);
        k = cyc; clear_obs(); start = 1'b1;
        step(1); start = 1'b0;
        chk("restart_layer", int'(layer), 0);
        chk("restart_iter", int'(iter), 0);
        wait_done(0, 80, "restart_done_seen");
        chk("restart_done_cycle", obs_done_cyc - k, 52);

        // Async reset in the middle of a PH_B cycle.
        step(2);
        k = cyc; clear_obs(); start = 1'b1;
        step(1); start = 1'b0;
        step(3);
        chk("pre_rst_wr_en", int'(wr_en), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_wr_en", int'(wr_en), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_layer", int'(layer), 0);
        chk("async_rst_iters_used", int'(iters_used), 0);
        step(2); rst = 1'b0;
        step(1);
        k = cyc; clear_obs(); start = 1'b1;
        step(1); start = 1'b0;
        wait_done(0, 80, "post_rst_done_seen");
        chk("post_rst_done_cycle", obs_done_cyc - k, 52);
        chk("post_rst_rd_count", obs_rd, 12);

        // Start held high: back-to-back decodes.
        step(2);
        k = cyc; clear_obs(); start = 1'b1;
        wait_done(0, 80, "held_first_done");
        first_done = obs_done_cyc;
        wait_done(1, 80, "held_second_done");
        start = 1'b0;
        chk("held_first_cycle", first_done - k, 52);
        chk("held_done_spacing", obs_done_cyc - first_done, 53);
        step(3);
        chk("held_idle_after", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
